pipeline_stall_controller: RTL and testbench

Central hazard and stall sequencer for the five-stage RISC-V pipeline. It decides the stall and clear (bubble) controls for the program-counter, fetch, decode, execution and memory stages each cycle. Its inputs are data-cache misses, instruction-cache misses, taken branches resolved in the execution stage, and load-use hazards between the decode and execution stages. It also tracks miss wait states, watchdogs long misses and counts stall cycles for performance monitoring.

---
 rtl/pipeline_stall_controller_if.sv | 44 ++++
 rtl/pipeline_stall_controller.sv | 116 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/stall control bundle between the pipeline datapath and the stall controller.
// The datapath drives hazard sources through master; the controller answers through slave.
interface pipeline_stall_controller_if;
  logic [4:0]  decode_rs1_address;
  logic        decode_rs1_used;
  logic [4:0]  decode_rs2_address;
  logic        decode_rs2_used;
  logic [4:0]  execution_rd_address;
  logic        execution_load;
  logic        execution_rd_write_enable;
  logic        branch_taken;
  logic        instruction_cache_ready;
  logic        data_cache_request;
  logic        data_cache_ready;

  logic        stall_program_counter_stage;
  logic        stall_instruction_fetch_stage;
  logic        stall_decode_stage;
  logic        stall_execution_stage;
  logic        stall_memory_stage;
  logic        clear_decode_stage;
  logic        clear_execution_stage;
  logic [1:0]  state;
  logic        miss_timeout;
  logic [15:0] stall_cycle_count;

  modport master (
    output decode_rs1_address, decode_rs1_used, decode_rs2_address, decode_rs2_used,
           execution_rd_address, execution_load, execution_rd_write_enable, branch_taken,
           instruction_cache_ready, data_cache_request, data_cache_ready,
    input  stall_program_counter_stage, stall_instruction_fetch_stage, stall_decode_stage,
           stall_execution_stage, stall_memory_stage, clear_decode_stage,
           clear_execution_stage, state, miss_timeout, stall_cycle_count
  );

  modport slave (
    input  decode_rs1_address, decode_rs1_used, decode_rs2_address, decode_rs2_used,
           execution_rd_address, execution_load, execution_rd_write_enable, branch_taken,
           instruction_cache_ready, data_cache_request, data_cache_ready,
    output stall_program_counter_stage, stall_instruction_fetch_stage, stall_decode_stage,
           stall_execution_stage, stall_memory_stage, clear_decode_stage,
           clear_execution_stage, state, miss_timeout, stall_cycle_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/bubble sequencer for the five-stage pipeline: Mealy stage controls,
// miss wait-state tracking, a sticky miss watchdog and a saturating stall-cycle counter.
module pipeline_stall_controller #(
  parameter int unsigned TimeoutCycles = 64
) (
  input logic                          clk,
  input logic                          rst_n,
  pipeline_stall_controller_if.slave   ctrl
);

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StDwait = 2'b01,
    StIwait = 2'b10
  } state_e;

  localparam logic [7:0] WaitMax = 8'(TimeoutCycles - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_count_q, wait_count_d;
  logic        miss_timeout_q, miss_timeout_d;
  logic [15:0] stall_cycle_count_q, stall_cycle_count_d;

  logic dmiss, imiss, load_use, rs1_hit, rs2_hit, stays_waiting;
  logic stall_pc, stall_if, stall_id, stall_ex, stall_mem, clear_id, clear_ex;

  assign dmiss   = ctrl.data_cache_request & ~ctrl.data_cache_ready;
  assign imiss   = ~ctrl.instruction_cache_ready;
  assign rs1_hit = ctrl.decode_rs1_used & (ctrl.decode_rs1_address == ctrl.execution_rd_address);
  assign rs2_hit = ctrl.decode_rs2_used & (ctrl.decode_rs2_address == ctrl.execution_rd_address);
  assign load_use = ctrl.execution_load & ctrl.execution_rd_write_enable &
                    (ctrl.execution_rd_address != 5'd0) & (rs1_hit | rs2_hit);

  // Stage controls; reset forces every stage to hold and bubble.
  always_comb begin
    stall_pc  = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    clear_id  = 1'b0;
    clear_ex  = 1'b0;
    if (!rst_n) begin
      {stall_pc, stall_if, stall_id, stall_ex, stall_mem} = 5'b11111;
      {clear_id, clear_ex} = 2'b11;
    end else if (dmiss) begin
      {stall_pc, stall_if, stall_id, stall_ex, stall_mem} = 5'b11111;
    end else if (ctrl.branch_taken) begin
      {clear_id, clear_ex} = 2'b11;
    end else if (load_use) begin
      {stall_pc, stall_if, stall_id} = 3'b111;
      clear_ex = 1'b1;
    end else if (imiss) begin
      {stall_pc, stall_if} = 2'b11;
      clear_id = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (dmiss)      state_d = StDwait;
        else if (imiss) state_d = StIwait;
      end
      StDwait: begin
        if (!dmiss)     state_d = imiss ? StIwait : StRun;
      end
      StIwait: begin
        if (dmiss)      state_d = StDwait;
        else if (!imiss) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign stays_waiting = (state_d == state_q) && (state_q != StRun);

  always_comb begin
    wait_count_d = '0;
    if (stays_waiting) begin
      wait_count_d = (wait_count_q == WaitMax) ? wait_count_q : wait_count_q + 8'd1;
    end
    miss_timeout_d = miss_timeout_q | (stays_waiting && (wait_count_q == WaitMax));
    stall_cycle_count_d = stall_cycle_count_q;
    if (stall_pc && (stall_cycle_count_q != 16'hFFFF)) begin
      stall_cycle_count_d = stall_cycle_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= StRun;
      wait_count_q        <= '0;
      miss_timeout_q      <= 1'b0;
      stall_cycle_count_q <= '0;
    end else begin
      state_q             <= state_d;
      wait_count_q        <= wait_count_d;
      miss_timeout_q      <= miss_timeout_d;
      stall_cycle_count_q <= stall_cycle_count_d;
    end
  end

  assign ctrl.stall_program_counter_stage   = stall_pc;
  assign ctrl.stall_instruction_fetch_stage = stall_if;
  assign ctrl.stall_decode_stage            = stall_id;
  assign ctrl.stall_execution_stage         = stall_ex;
  assign ctrl.stall_memory_stage            = stall_mem;
  assign ctrl.clear_decode_stage            = clear_id;
  assign ctrl.clear_execution_stage         = clear_ex;
  assign ctrl.state                         = state_q;
  assign ctrl.miss_timeout                  = miss_timeout_q;
  assign ctrl.stall_cycle_count             = stall_cycle_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller (default watchdog of 64 cycles).
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  pipeline_stall_controller_if bus ();

  pipeline_stall_controller #(.TimeoutCycles(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  // {pc, if, id, ex, mem stall, decode clear, execution clear}
  logic [6:0] ctl;
  assign ctl = {bus.stall_program_counter_stage, bus.stall_instruction_fetch_stage,
                bus.stall_decode_stage, bus.stall_execution_stage, bus.stall_memory_stage,
                bus.clear_decode_stage, bus.clear_execution_stage};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.decode_rs1_address        = 5'd0;
    bus.decode_rs1_used           = 1'b0;
    bus.decode_rs2_address        = 5'd0;
    bus.decode_rs2_used           = 1'b0;
    bus.execution_rd_address      = 5'd0;
    bus.execution_load            = 1'b0;
    bus.execution_rd_write_enable = 1'b0;
    bus.branch_taken              = 1'b0;
    bus.instruction_cache_ready   = 1'b1;
    bus.data_cache_request        = 1'b0;
    bus.data_cache_ready          = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("reset_ctl", 32'(ctl), 32'h7F);
    check("reset_state", 32'(bus.state), 32'h0);
    check("reset_timeout", 32'(bus.miss_timeout), 32'h0);
    check("reset_count", 32'(bus.stall_cycle_count), 32'h0);

    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("idle_ctl", 32'(ctl), 32'h00);

    // Load-use through rs2, then rd = x0, rs1 path, and a non-writing load.
    bus.execution_load = 1'b1;
    bus.execution_rd_write_enable = 1'b1;
    bus.execution_rd_address = 5'd5;
    bus.decode_rs2_used = 1'b1;
    bus.decode_rs2_address = 5'd5;
    #1;
    check("load_use_rs2", 32'(ctl), 32'h71);
    bus.execution_rd_address = 5'd0;
    bus.decode_rs2_address = 5'd0;
    #1;
    check("load_use_x0", 32'(ctl), 32'h00);
    bus.decode_rs2_used = 1'b0;
    bus.decode_rs1_used = 1'b1;
    bus.decode_rs1_address = 5'd7;
    bus.execution_rd_address = 5'd7;
    #1;
    check("load_use_rs1", 32'(ctl), 32'h71);
    bus.execution_rd_write_enable = 1'b0;
    #1;
    check("load_no_write", 32'(ctl), 32'h00);
    idle_inputs();
    tick();
    check("count_after_idle", 32'(bus.stall_cycle_count), 32'd0);

    // Data miss for three edges.
    bus.data_cache_request = 1'b1;
    #1;
    check("dmiss_ctl", 32'(ctl), 32'h7C);
    check("dmiss_state_pre", 32'(bus.state), 32'h0);
    tick();
    check("dmiss_state", 32'(bus.state), 32'h1);
    check("dmiss_ctl_hold", 32'(ctl), 32'h7C);
    tick();
    tick();
    check("dmiss_count", 32'(bus.stall_cycle_count), 32'd3);
    bus.data_cache_ready = 1'b1;
    #1;
    check("dmiss_release_ctl", 32'(ctl), 32'h00);
    tick();
    check("dmiss_release_state", 32'(bus.state), 32'h0);
    check("dmiss_release_count", 32'(bus.stall_cycle_count), 32'd3);

    // Ready in the same cycle as the request: no miss.
    tick();
    check("hit_ctl", 32'(ctl), 32'h00);
    check("hit_state", 32'(bus.state), 32'h0);
    idle_inputs();

    // Branch beats imiss and load-use; dmiss beats branch.
    bus.branch_taken = 1'b1;
    bus.instruction_cache_ready = 1'b0;
    bus.execution_load = 1'b1;
    bus.execution_rd_write_enable = 1'b1;
    bus.execution_rd_address = 5'd5;
    bus.decode_rs2_used = 1'b1;
    bus.decode_rs2_address = 5'd5;
    #1;
    check("branch_prio", 32'(ctl), 32'h03);
    bus.data_cache_request = 1'b1;
    #1;
    check("dmiss_over_branch", 32'(ctl), 32'h7C);
    idle_inputs();
    bus.instruction_cache_ready = 1'b0;
    #1;
    check("imiss_ctl", 32'(ctl), 32'h62);

    // Instruction miss held 70 edges after entry; watchdog fires at edge 64.
    tick();
    check("iwait_state", 32'(bus.state), 32'h2);
    repeat (63) tick();
    check("timeout_before", 32'(bus.miss_timeout), 32'h0);
    tick();
    check("timeout_at_64", 32'(bus.miss_timeout), 32'h1);
    repeat (6) tick();
    check("iwait_state_70", 32'(bus.state), 32'h2);
    check("iwait_count", 32'(bus.stall_cycle_count), 32'd74);
    bus.instruction_cache_ready = 1'b1;
    #1;
    check("imiss_release_ctl", 32'(ctl), 32'h00);
    tick();
    check("iwait_exit_state", 32'(bus.state), 32'h0);
    check("timeout_sticky", 32'(bus.miss_timeout), 32'h1);

    // Long miss saturates the stall counter.
    bus.instruction_cache_ready = 1'b0;
    repeat (70000) tick();
    check("count_saturated", 32'(bus.stall_cycle_count), 32'hFFFF);
    tick();
    check("count_no_wrap", 32'(bus.stall_cycle_count), 32'hFFFF);

    // Reset in the middle of a data miss.
    bus.instruction_cache_ready = 1'b1;
    bus.data_cache_request = 1'b1;
    tick();
    check("pre_reset_state", 32'(bus.state), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midmiss_reset_ctl", 32'(ctl), 32'h7F);
    check("midmiss_reset_state", 32'(bus.state), 32'h0);
    check("midmiss_reset_timeout", 32'(bus.miss_timeout), 32'h0);
    check("midmiss_reset_count", 32'(bus.stall_cycle_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_ctl", 32'(ctl), 32'h7C);
    check("post_reset_state", 32'(bus.state), 32'h0);
    tick();
    check("post_reset_dwait", 32'(bus.state), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
